ipg_egress_arbiter: RTL and testbench

- Shares one egress IPG slot between N_PORTS ingress receivers.
- Each receiver's rx_ipg_en / rx_fwd_ipg_data pair feeds a per-port input filter and FIFO. The filter keeps only messages addressed to this egress port.
- A message-granular round-robin scheduler drains the FIFOs into a single ready/valid stream toward the egress TX path.
- Sits between the ingress blocks and one switch egress port. One instance per egress port.

---
 rtl/ipg_egress_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_ipg_egress_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ipg_egress_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ipg_egress_arbiter
// Brief    : Per-port address filters and FIFOs feeding a message-granular
//            round-robin scheduler that drives one egress IPG stream.
// Revision : 1.0 - initial release
// ============================================================================
module ipg_egress_arbiter #(
    parameter int N_PORTS    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADR_WIDTH  = 40,
    parameter int FIFO_DEPTH = 8,
    parameter logic [ADR_WIDTH/2-1:0] PORT_ADDR  = 20'h00001,
    parameter logic [ADR_WIDTH/2-1:0] BCAST_ADDR = 20'hFFFFF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_PORTS-1:0]              in_valid,
    input  logic [N_PORTS*DATA_WIDTH-1:0]   in_data,
    input  logic                            out_ready,
    output logic                            out_valid,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic                            out_sop,
    output logic                            out_eop,
    output logic [$clog2(N_PORTS)-1:0]      out_port,
    output logic [N_PORTS-1:0]              drop,
    output logic [N_PORTS-1:0]              orphan
);

    localparam int c_IW = $clog2(N_PORTS);
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_AW = ADR_WIDTH / 2;

    localparam logic [1:0] c_F_IDLE    = 2'd0;
    localparam logic [1:0] c_F_ACCEPT  = 2'd1;
    localparam logic [1:0] c_F_DISCARD = 2'd2;

    localparam logic c_S_IDLE = 1'b0;
    localparam logic c_S_XFER = 1'b1;

    logic [N_PORTS-1:0]  w_nonempty;
    logic [N_PORTS-1:0]  w_pop;
    logic [DATA_WIDTH:0] w_head [N_PORTS];
    logic [DATA_WIDTH:0] w_cur;
    logic                w_fire;

    logic                r_sst;
    logic                w_sst_nxt;
    logic [c_IW-1:0]     r_gnt;
    logic [c_IW-1:0]     r_rr_ptr;
    logic                r_first;
    logic                w_found;
    logic [c_IW-1:0]     w_pick;
    logic [c_IW-1:0]     w_idx;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        logic [DATA_WIDTH-1:0] w_word;
        logic [15:0]           w_len;
        logic [c_AW-1:0]       w_dst;
        logic                  w_is_hdr;
        logic                  w_match;
        logic [16:0]           w_free;
        logic                  w_fits;
        logic [1:0]            r_fst;
        logic [1:0]            w_fst_nxt;
        logic [15:0]           r_rem;
        logic [15:0]           w_rem_nxt;
        logic                  w_push;
        logic                  w_push_eop;
        logic                  w_drop_nxt;
        logic                  w_orphan_nxt;
        logic                  r_drop;
        logic                  r_orphan;
        logic [DATA_WIDTH:0]   r_mem [FIFO_DEPTH];
        logic [c_PW-1:0]       r_wr_ptr;
        logic [c_PW-1:0]       r_rd_ptr;
        logic [c_CW-1:0]       r_count;

        assign w_word   = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_len    = w_word[DATA_WIDTH-1 -: 16];
        assign w_dst    = w_word[8 +: c_AW];
        assign w_is_hdr = (w_word[7:4] == 4'h2);
        assign w_match  = (w_dst == PORT_ADDR) || (w_dst == BCAST_ADDR);
        // Occupancy before any same-cycle pop, so a whole message always fits.
        assign w_free   = 17'(FIFO_DEPTH) - 17'(r_count);
        assign w_fits   = (w_free >= ({1'b0, w_len} + 17'd1));

        always_comb begin
            w_fst_nxt    = r_fst;
            w_rem_nxt    = r_rem;
            w_push       = 1'b0;
            w_push_eop   = 1'b0;
            w_drop_nxt   = 1'b0;
            w_orphan_nxt = 1'b0;
            if (in_valid[i]) begin
                case (r_fst)
                    c_F_IDLE: begin
                        if (w_is_hdr) begin
                            w_rem_nxt = w_len;
                            if (w_match && w_fits) begin
                                w_push     = 1'b1;
                                w_push_eop = (w_len == 16'd0);
                                if (w_len != 16'd0) w_fst_nxt = c_F_ACCEPT;
                            end else begin
                                w_drop_nxt = w_match;
                                if (w_len != 16'd0) w_fst_nxt = c_F_DISCARD;
                            end
                        end else begin
                            w_orphan_nxt = 1'b1;
                        end
                    end
                    c_F_ACCEPT, c_F_DISCARD: begin
                        w_push     = (r_fst == c_F_ACCEPT);
                        w_push_eop = (r_rem == 16'd1);
                        w_rem_nxt  = r_rem - 16'd1;
                        if (r_rem == 16'd1) w_fst_nxt = c_F_IDLE;
                    end
                    default: w_fst_nxt = c_F_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                r_fst    <= c_F_IDLE;
                r_rem    <= '0;
                r_drop   <= 1'b0;
                r_orphan <= 1'b0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                r_fst    <= w_fst_nxt;
                r_rem    <= w_rem_nxt;
                r_drop   <= w_drop_nxt;
                r_orphan <= w_orphan_nxt;
                if (w_push)   r_wr_ptr <= r_wr_ptr + c_PW'(1);
                if (w_pop[i]) r_rd_ptr <= r_rd_ptr + c_PW'(1);
                r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop[i]);
            end
        end

        always_ff @(posedge clk) begin
            if (w_push) r_mem[r_wr_ptr] <= {w_push_eop, w_word};
        end

        assign w_nonempty[i] = (r_count != '0);
        assign w_head[i]     = r_mem[r_rd_ptr];
        assign drop[i]       = r_drop;
        assign orphan[i]     = r_orphan;
    end

    // Round-robin search starting one past the last port that completed a message.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 1; k <= N_PORTS; k++) begin
            w_idx = c_IW'((32'(r_rr_ptr) + 32'(k)) % N_PORTS);
            if (!w_found && w_nonempty[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_cur     = w_head[r_gnt];
    assign out_valid = (r_sst == c_S_XFER) && w_nonempty[r_gnt];
    assign out_data  = out_valid ? w_cur[DATA_WIDTH-1:0] : '0;
    assign out_eop   = out_valid && w_cur[DATA_WIDTH];
    assign out_sop   = out_valid && r_first;
    assign out_port  = r_gnt;
    assign w_fire    = out_valid && out_ready;

    always_comb begin
        w_pop        = '0;
        w_pop[r_gnt] = w_fire;
    end

    always_comb begin
        w_sst_nxt = r_sst;
        case (r_sst)
            c_S_IDLE: if (w_found) w_sst_nxt = c_S_XFER;
            c_S_XFER: if (w_fire && w_cur[DATA_WIDTH]) w_sst_nxt = c_S_IDLE;
            default:  w_sst_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sst    <= c_S_IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= c_IW'(N_PORTS - 1);
            r_first  <= 1'b0;
        end else begin
            r_sst <= w_sst_nxt;
            if (r_sst == c_S_IDLE && w_found) begin
                r_gnt   <= w_pick;
                r_first <= 1'b1;
            end
            if (w_fire) begin
                r_first <= 1'b0;
                if (w_cur[DATA_WIDTH]) r_rr_ptr <= r_gnt;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ipg_egress_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ipg_egress_arbiter
// Brief    : Scoreboard bench with a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ipg_egress_arbiter;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int FD = 8;
    localparam logic [19:0] PA = 20'h00001;
    localparam logic [19:0] BA = 20'hFFFFF;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic            out_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_sop;
    logic            out_eop;
    logic [1:0]      out_port;
    logic [N-1:0]    drop;
    logic [N-1:0]    orphan;

    ipg_egress_arbiter #(
        .N_PORTS(N), .DATA_WIDTH(DW), .ADR_WIDTH(40), .FIFO_DEPTH(FD),
        .PORT_ADDR(PA), .BCAST_ADDR(BA)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_port(out_port),
        .drop(drop), .orphan(orphan)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] data;
    } ent_t;

    ent_t         exp_q [N][$];
    int           checks = 0;
    int           errors = 0;
    int           f_mode [N];
    int           f_rem  [N];
    logic [N-1:0] exp_drop   = '0;
    logic [N-1:0] exp_orphan = '0;
    logic [N-1:0] ne1 = '0;
    logic [N-1:0] ne2 = '0;
    int           last_gnt = N - 1;
    bit           in_msg = 1'b0;
    int           cur_port = 0;
    int           occ [N];
    int           gen_rem [N];

    // Reference model and monitor: each negedge predicts the effect of the
    // coming posedge and checks what the DUT presents now.
    always @(negedge clk) begin : model_mon
        ent_t        e;
        logic [63:0] w;
        int          len;
        int          ep;
        bit          match;
        checks++;
        if (drop !== exp_drop) begin
            errors++;
            $display("FAIL drop got=%b exp=%b t=%0t", drop, exp_drop, $time);
        end
        checks++;
        if (orphan !== exp_orphan) begin
            errors++;
            $display("FAIL orphan got=%b exp=%b t=%0t", orphan, exp_orphan, $time);
        end
        exp_drop   = '0;
        exp_orphan = '0;
        if (rst) begin
            for (int p = 0; p < N; p++) begin
                exp_q[p].delete();
                f_mode[p] = 0;
                f_rem[p]  = 0;
            end
            last_gnt = N - 1;
            in_msg   = 1'b0;
            ne1      = '0;
            ne2      = '0;
        end else begin
            for (int p = 0; p < N; p++) occ[p] = exp_q[p].size();
            if (out_valid === 1'b1 && !in_msg) begin
                ep = -1;
                for (int k = 1; k <= N; k++)
                    if (ep < 0 && ne2[(last_gnt + k) % N]) ep = (last_gnt + k) % N;
                checks++;
                if (int'(out_port) != ep) begin
                    errors++;
                    $display("FAIL grant got=%0d exp=%0d t=%0t", out_port, ep, $time);
                end
                in_msg   = 1'b1;
                cur_port = int'(out_port);
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                checks++;
                if (int'(out_port) != cur_port) begin
                    errors++;
                    $display("FAIL interleave got=%0d exp=%0d", out_port, cur_port);
                end else if (exp_q[cur_port].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected port=%0d data=%h", out_port, out_data);
                end else begin
                    e = exp_q[cur_port].pop_front();
                    if (out_data !== e.data || out_sop !== e.sop || out_eop !== e.eop) begin
                        errors++;
                        $display("FAIL word port=%0d got=%h sop=%b eop=%b exp=%h sop=%b eop=%b",
                                 cur_port, out_data, out_sop, out_eop, e.data, e.sop, e.eop);
                    end
                    if (e.eop) begin
                        last_gnt = cur_port;
                        in_msg   = 1'b0;
                    end
                end
            end
            for (int p = 0; p < N; p++) begin
                if (in_valid[p]) begin
                    w = in_data[p*DW +: DW];
                    if (f_mode[p] == 0) begin
                        if (w[7:4] == 4'h2) begin
                            len   = int'(w[63:48]);
                            match = (w[27:8] == PA) || (w[27:8] == BA);
                            if (match && (FD - occ[p] >= len + 1)) begin
                                exp_q[p].push_back('{1'b1, len == 0, w});
                                f_mode[p] = (len != 0) ? 1 : 0;
                            end else begin
                                if (match) exp_drop[p] = 1'b1;
                                f_mode[p] = (len != 0) ? 2 : 0;
                            end
                            f_rem[p] = len;
                        end else begin
                            exp_orphan[p] = 1'b1;
                        end
                    end else begin
                        if (f_mode[p] == 1) exp_q[p].push_back('{1'b0, f_rem[p] == 1, w});
                        f_rem[p]--;
                        if (f_rem[p] == 0) f_mode[p] = 0;
                    end
                end
            end
            ne2 = ne1;
            for (int p = 0; p < N; p++) ne1[p] = (exp_q[p].size() != 0);
        end
    end

    function automatic logic [63:0] hdr(input int len, input logic [19:0] dst);
        logic [19:0] src;
        src = 20'($urandom);
        return {16'(len), src, dst, 4'h2, 4'($urandom)};
    endfunction

    function automatic logic [63:0] rnd_word();
        return {$urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        in_valid = '0;
    endtask

    task automatic drive(input int p, input logic [63:0] w);
        in_valid[p]         = 1'b1;
        in_data[p*DW +: DW] = w;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic bit pending();
        for (int p = 0; p < N; p++) if (exp_q[p].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while ((pending() || out_valid === 1'b1) && n < budget) begin
            tick();
            n++;
        end
        repeat (2) tick();
        checks++;
        if (pending()) begin
            errors++;
            $display("FAIL drain timeout after %0d cycles", budget);
        end
    endtask

    task automatic chk_zero(input string tag);
        #2;
        chk({tag, "_valid"},  64'(out_valid), 64'd0);
        chk({tag, "_sop"},    64'(out_sop),   64'd0);
        chk({tag, "_eop"},    64'(out_eop),   64'd0);
        chk({tag, "_port"},   64'(out_port),  64'd0);
        chk({tag, "_data"},   out_data,       64'd0);
        chk({tag, "_drop"},   64'(drop),      64'd0);
        chk({tag, "_orphan"}, 64'(orphan),    64'd0);
    endtask

    task automatic send_msg(input int p, input int len, input logic [19:0] dst);
        drive(p, hdr(len, dst));
        tick();
        for (int k = 0; k < len; k++) begin
            drive(p, rnd_word());
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        for (int p = 0; p < N; p++) gen_rem[p] = 0;
        repeat (3) tick();
        rst = 1'b0;
        chk_zero("reset");
        tick();

        // Latency of a single message with an idle scheduler.
        drive(0, hdr(2, PA));
        tick();
        drive(0, rnd_word());
        #2 chk("lat_before_grant", 64'(out_valid), 64'd0);
        tick();
        drive(0, rnd_word());
        #2 chk("lat_after_grant", 64'(out_valid), 64'd1);
        tick();
        drain(50);

        // Simultaneous arrivals, then a round after port 1 was last granted.
        for (int p = 0; p < N; p++) drive(p, hdr(1, (p == 3) ? BA : PA));
        tick();
        for (int p = 0; p < N; p++) drive(p, rnd_word());
        tick();
        drain(50);
        send_msg(1, 0, PA);
        drain(50);
        for (int p = 0; p < N; p++) drive(p, hdr(1, PA));
        tick();
        for (int p = 0; p < N; p++) drive(p, rnd_word());
        tick();
        drain(50);

        // Misrouted message followed by a matching one.
        send_msg(2, 3, 20'h00002);
        send_msg(2, 1, PA);
        drain(50);

        // Space-based drop with the egress stalled.
        out_ready = 1'b0;
        send_msg(1, 5, PA);
        send_msg(1, 2, PA);
        send_msg(1, 1, BA);
        repeat (3) tick();
        out_ready = 1'b1;
        drain(50);

        // Orphan word and oversize header.
        drive(2, {56'h0123456789ABCD, 4'h1, 4'h0});
        tick();
        send_msg(2, 8, PA);
        drain(50);

        // Reset in the middle of a transfer.
        drive(0, hdr(3, PA));
        tick();
        drive(0, rnd_word());
        tick();
        drive(0, rnd_word());
        out_ready = 1'b0;
        tick();
        drive(0, rnd_word());
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("midrst");
        drive(2, hdr(1, PA));
        drive(0, hdr(1, PA));
        tick();
        drive(2, rnd_word());
        drive(0, rnd_word());
        tick();
        drain(50);

        // Randomized traffic with stall bursts.
        for (int cyc = 0; cyc < 2500; cyc++) begin
            if (((cyc / 50) % 4) == 3) out_ready = ($urandom % 8) == 0;
            else                       out_ready = ($urandom % 4) != 0;
            for (int p = 0; p < N; p++) begin
                if (gen_rem[p] > 0) begin
                    if (($urandom % 10) < 7) begin
                        drive(p, rnd_word());
                        gen_rem[p]--;
                    end
                end else if (cyc < 2400 && ($urandom % 8) == 0) begin
                    int kind;
                    int len;
                    kind = int'($urandom % 10);
                    if (kind < 6) begin
                        len = int'($urandom % 10);
                        drive(p, hdr(len, (kind < 4) ? PA : BA));
                        gen_rem[p] = len;
                    end else if (kind < 9) begin
                        len = int'($urandom % 5);
                        drive(p, hdr(len, 20'h00100 | 20'($urandom % 256)));
                        gen_rem[p] = len;
                    end else begin
                        drive(p, {$urandom, 24'($urandom), 4'h3, 4'($urandom)});
                    end
                end
            end
            tick();
        end
        out_ready = 1'b1;
        drain(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
